uop_issue_queue: RTL and testbench
==================================

Name: uop_issue_queue

Overview:
- Consumer end of the decoder feed handshake.
- Drives `feed_req` to the decode unit. On each `feed_ack` it captures the micro-op bundle (`uop_0`/`uop_1`/`uop_2`, `uop_count`) and expands it into an in-order FIFO of 20-bit micro-ops.
- Presents one micro-op per cycle to the execute stage with a valid/ready handshake.
- Sits between the decode unit and the ALU/load-store execute stage.

Parameters:
- `DEPTH`, 8, FIFO entries; power of two; minimum 4.
- `AW`, 3, pointer width, equal to log2(`DEPTH`).

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `a_rst`  input  1  asynchronous reset, active-high.
- `flush`  input  1  synchronous discard of all queued micro-ops (pc redirect).
- `feed_req`  output  1  queue can accept a full bundle this cycle.
- `feed_ack`  input  1  decoder issued a bundle this cycle.
- `uop_0`  input  20  final micro-op of the bundle.
- `uop_1`  input  20  middle micro-op.
- `uop_2`  input  20  first micro-op when `uop_count` is 2.
- `uop_count`  input  2  number of micro-ops preceding `uop_0`: 0, 1 or 2.
- `uop_out`  output  20  micro-op at the FIFO head.
- `uop_valid`  output  1  `uop_out` is valid.
- `uop_last`  output  1  head micro-op is the last of its instruction.
- `uop_ready`  input  1  execute stage accepts the head this cycle.
- `occupancy`  output  AW+1  number of valid entries.

Behaviour:
- Storage:
  - `DEPTH` entries of 21 bits: 20-bit micro-op plus a `last` flag.
  - Write pointer `wp`, read pointer `rp`, `AW` bits each, both wrap modulo `DEPTH`.
  - `occupancy` register counts 0..`DEPTH`.
- Reset (`a_rst` high, asynchronous):
  - `wp`=0, `rp`=0, `occupancy`=0.
  - `uop_valid`=0, `uop_last`=0, `uop_out`=0.
  - `feed_req`=0 while `a_rst` is high.
- `feed_req`:
  - Combinational from registered state only.
  - Equals `~a_rst & ~flush & (DEPTH - occupancy >= 3)`.
  - Never depends on `uop_count`, `feed_ack` or `uop_ready`, so no combinational loop exists with the decoder.
- Push on `feed_ack & ~flush`:
  - Number of entries pushed: n = `uop_count` + 1.
  - `uop_count`=3 is illegal and treated as 2.
  - `uop_count`=2: write `uop_2`, then `uop_1`, then `uop_0`.
  - `uop_count`=1: write `uop_1`, then `uop_0`.
  - `uop_count`=0: write `uop_0` only.
  - Entries go to consecutive slots `wp`, `wp`+1, `wp`+2 (mod `DEPTH`).
  - `last`=1 only on the `uop_0` entry.
  - `wp` advances by n in the same cycle.
  - `feed_ack` while `feed_req`=0 is a protocol error: the bundle is dropped and state is unchanged.
- Pop on `uop_valid & uop_ready & ~flush`:
  - `rp` advances by 1.
- Head outputs:
  - `uop_valid` = (`occupancy` != 0); `uop_out` = entry[`rp`]; `uop_last` = entry[`rp`].last.
  - When `occupancy`=0, `uop_out`=0 and `uop_last`=0.
  - Latency: a bundle acked in cycle t gives `uop_valid`=1 in cycle t+1. There is no bypass from decoder to output.
- Simultaneous push and pop in one cycle: `occupancy` next = `occupancy` + n − 1. Both pointers update.
- Full and empty boundaries:
  - `occupancy` never exceeds `DEPTH`; this is guaranteed by the ≥3-free rule.
  - Pop when empty is impossible because `uop_valid`=0.
- Flush:
  - Next cycle: `wp`=`rp`=0, `occupancy`=0.
  - Same cycle: any concurrent `feed_ack` is ignored, and the head is not counted as consumed even if `uop_ready`=1.
  - `feed_req`=0 during the flush cycle.
- Reset asserted mid-bundle or mid-drain: all state clears immediately; partial bundles are discarded.

Test Plan:
- Reset, then idle -> `feed_req`=1, `uop_valid`=0, `occupancy`=0.
- Push `uop_count`=2 with `uop_2`=h00003, `uop_1`=h00002, `uop_0`=h00001, `uop_ready`=1 -> outputs h00003, h00002, h00001 on cycles t+1..t+3; `uop_last`=1 only on h00001; `occupancy` back to 0.
- `uop_ready`=0; ack bundles with counts 2 then 2 (`DEPTH`=8) -> `occupancy`=6, `feed_req`=0; one pop -> `occupancy`=5, `feed_req`=1.
- Queue holds 1 entry; `feed_ack` with `uop_count`=1 and a pop in the same cycle -> `occupancy`=2, order preserved.
- Run 20 single-uop bundles with random `uop_ready` -> pointers wrap past 7, output order matches input order, no loss.
- Queue holds 5 entries; assert `flush` together with `feed_ack` and `uop_ready` -> next cycle `occupancy`=0, `uop_valid`=0, acked bundle absent. Repeat the scenario with `a_rst` pulsed mid-drain -> immediate clear.

Source files
------------

// File: rtl/uop_issue_queue.sv
// ---------------------------------------------------------------------------
// uop_issue_queue
//
// Consumer end of the decoder feed handshake. Each acknowledged bundle of one
// to three micro-ops is expanded into an in-order FIFO, which presents one
// micro-op per cycle to the execute stage over a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   a_rst      asynchronous reset, active-high
//   flush      synchronous discard of all queued micro-ops
//   feed_req   queue has room for a full three-entry bundle
//   feed_ack   decoder issues a bundle this cycle
//   uop_0      final micro-op of the bundle (carries the last flag)
//   uop_1      middle micro-op
//   uop_2      first micro-op when uop_count is 2
//   uop_count  micro-ops preceding uop_0 (0..2; 3 is treated as 2)
//   uop_out    micro-op at the FIFO head (0 when empty)
//   uop_valid  uop_out is valid
//   uop_last   head micro-op ends its instruction
//   uop_ready  execute stage consumes the head this cycle
//   occupancy  number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module uop_issue_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          a_rst,
    input  logic          flush,
    output logic          feed_req,
    input  logic          feed_ack,
    input  logic [19:0]   uop_0,
    input  logic [19:0]   uop_1,
    input  logic [19:0]   uop_2,
    input  logic [1:0]    uop_count,
    output logic [19:0]   uop_out,
    output logic          uop_valid,
    output logic          uop_last,
    input  logic          uop_ready,
    output logic [AW:0]   occupancy
);

    // Entry layout: bit 20 is the last flag, bits 19:0 the micro-op.
    logic [20:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    logic [20:0]   wdata_0;
    logic [20:0]   wdata_1;
    logic [20:0]   wdata_2;
    logic [1:0]    push_n;
    logic          push;
    logic          pop;
    logic [AW:0]   occ_next;
    logic [AW:0]   free_slots;
    logic [20:0]   head;

    // Admission only looks at registered occupancy, so feed_req can never
    // form a combinational loop through the decoder's feed_ack.
    assign free_slots = (AW+1)'(DEPTH) - occupancy;
    assign feed_req   = ~a_rst & ~flush & (free_slots >= (AW+1)'(3));

    // A bundle acked without feed_req is a protocol error and is dropped.
    assign push = feed_ack & feed_req;
    assign pop  = uop_valid & uop_ready & ~flush;

    // Lay the bundle out in program order: the oldest micro-op goes to wp.
    always_comb begin
        wdata_0 = '0;
        wdata_1 = '0;
        wdata_2 = '0;
        push_n  = 2'd1;
        case (uop_count)
            2'd0: begin
                wdata_0 = {1'b1, uop_0};
                push_n  = 2'd1;
            end
            2'd1: begin
                wdata_0 = {1'b0, uop_1};
                wdata_1 = {1'b1, uop_0};
                push_n  = 2'd2;
            end
            default: begin  // 2, and the illegal 3
                wdata_0 = {1'b0, uop_2};
                wdata_1 = {1'b0, uop_1};
                wdata_2 = {1'b1, uop_0};
                push_n  = 2'd3;
            end
        endcase
    end

    assign occ_next = occupancy
                    + (AW+1)'(push ? push_n : 2'd0)
                    - (AW+1)'(pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wp        <= '0;
            rp        <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wp        <= '0;
            rp        <= '0;
            occupancy <= '0;
        end else begin
            if (push) wp <= wp + AW'(push_n);
            if (pop)  rp <= rp + AW'(1);
            occupancy <= occ_next;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy alone
    // decides which entries are meaningful, and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wdata_0;
            if (push_n >= 2'd2) mem[wp + AW'(1)] <= wdata_1;
            if (push_n == 2'd3) mem[wp + AW'(2)] <= wdata_2;
        end
    end

    // No bypass: the head is always read from storage.
    assign head      = mem[rp];
    assign uop_valid = (occupancy != '0);
    assign uop_out   = uop_valid ? head[19:0] : 20'd0;
    assign uop_last  = uop_valid & head[20];

endmodule

// File: tb/tb_uop_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_uop_issue_queue
//
// Directed scenarios followed by randomized traffic, compared every cycle
// against a queue-based reference model of the micro-op FIFO.
// ---------------------------------------------------------------------------
module tb_uop_issue_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          a_rst = 1'b0;
    logic          flush = 1'b0;
    logic          feed_req;
    logic          feed_ack = 1'b0;
    logic [19:0]   uop_0 = '0;
    logic [19:0]   uop_1 = '0;
    logic [19:0]   uop_2 = '0;
    logic [1:0]    uop_count = '0;
    logic [19:0]   uop_out;
    logic          uop_valid;
    logic          uop_last;
    logic          uop_ready = 1'b0;
    logic [AW:0]   occupancy;

    int total = 0;
    int bad   = 0;

    // Reference model: bit 20 = last flag, bits 19:0 = micro-op.
    logic [20:0] model_q [$];
    int          seq = 1;

    uop_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .flush     (flush),
        .feed_req  (feed_req),
        .feed_ack  (feed_ack),
        .uop_0     (uop_0),
        .uop_1     (uop_1),
        .uop_2     (uop_2),
        .uop_count (uop_count),
        .uop_out   (uop_out),
        .uop_valid (uop_valid),
        .uop_last  (uop_last),
        .uop_ready (uop_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every visible output with the model's view of the queue.
    task automatic check_outputs(input string tag, input logic fl);
        logic exp_req;
        exp_req = !a_rst && !fl && ((DEPTH - model_q.size()) >= 3);
        check({tag, "_req"},   32'(feed_req),  32'(exp_req));
        check({tag, "_occ"},   32'(occupancy), 32'(model_q.size()));
        check({tag, "_valid"}, 32'(uop_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check({tag, "_out"},  32'(uop_out),  32'(model_q[0][19:0]));
            check({tag, "_last"}, 32'(uop_last), 32'(model_q[0][20]));
        end else begin
            check({tag, "_out"},  32'(uop_out),  32'd0);
            check({tag, "_last"}, 32'(uop_last), 32'd0);
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model
    // by the rules for accept, consume and flush.
    task automatic cycle(input string tag, input logic ack, input logic [1:0] cnt,
                         input logic [19:0] a0, input logic [19:0] a1,
                         input logic [19:0] a2, input logic rdy, input logic fl);
        bit do_push;
        bit do_pop;
        int n;
        @(negedge clk);
        feed_ack  = ack;
        uop_count = cnt;
        uop_0     = a0;
        uop_1     = a1;
        uop_2     = a2;
        uop_ready = rdy;
        flush     = fl;
        #1;
        check_outputs(tag, fl);
        do_push = ack && !fl && ((DEPTH - model_q.size()) >= 3);
        do_pop  = rdy && !fl && (model_q.size() != 0);
        n       = (cnt == 2'd0) ? 1 : (cnt == 2'd1) ? 2 : 3;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                if (n == 3) model_q.push_back({1'b0, a2});
                if (n >= 2) model_q.push_back({1'b0, a1});
                model_q.push_back({1'b1, a0});
            end
        end
    endtask

    task automatic idle(input string tag, input logic rdy);
        cycle(tag, 1'b0, 2'd0, 20'd0, 20'd0, 20'd0, rdy, 1'b0);
    endtask

    // Bundle with distinct, sequential payloads so ordering errors show up.
    task automatic bundle(input string tag, input logic [1:0] cnt, input logic rdy);
        cycle(tag, 1'b1, cnt, 20'(seq), 20'(seq + 1), 20'(seq + 2), rdy, 1'b0);
        seq += 3;
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_reset(input string tag);
        @(negedge clk);
        feed_ack  = 1'b0;
        uop_ready = 1'b0;
        flush     = 1'b0;
        #2 a_rst = 1'b1;
        #1;
        model_q.delete();
        check({tag, "_rst_occ"},   32'(occupancy), 32'd0);
        check({tag, "_rst_valid"}, 32'(uop_valid), 32'd0);
        check({tag, "_rst_req"},   32'(feed_req),  32'd0);
        check({tag, "_rst_out"},   32'(uop_out),   32'd0);
        @(negedge clk);
        #1;
        check_outputs({tag, "_inrst"}, 1'b0);
        a_rst = 1'b0;
    endtask

    initial begin
        // Reset, then idle.
        async_reset("init");
        idle("idle0", 1'b0);
        idle("idle1", 1'b0);

        // Three-entry bundle drained at full rate.
        cycle("b3", 1'b1, 2'd2, 20'h00001, 20'h00002, 20'h00003, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("b3_head_exp", 32'(model_q[0][19:0]), 32'(3 - i));
            idle("b3_drain", 1'b1);
        end
        idle("b3_empty", 1'b1);

        // Fill to 6 with ready low: feed_req must drop, then return after a pop.
        bundle("fill_a", 2'd2, 1'b0);
        bundle("fill_b", 2'd2, 1'b0);
        idle("full6", 1'b0);
        idle("pop1", 1'b1);
        idle("occ5", 1'b0);
        // A bundle at occupancy 6 would be refused; ack at 5 is accepted.
        bundle("at5", 2'd0, 1'b0);
        for (int i = 0; i < 7; i++) idle("drain6", 1'b1);

        // One queued entry, then simultaneous push of two and a pop.
        bundle("one", 2'd0, 1'b0);
        bundle("pushpop", 2'd1, 1'b1);
        idle("pp_occ2", 1'b1);
        idle("pp_next", 1'b1);
        idle("pp_empty", 1'b0);

        // Twenty single-micro-op bundles with random ready: pointers wrap.
        for (int i = 0; i < 20; i++) begin
            if ((DEPTH - model_q.size()) >= 3) bundle("wrap", 2'd0, 1'($urandom_range(0, 1)));
            else idle("wrap_stall", 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 12; i++) idle("wrap_drain", 1'b1);

        // Five entries, then flush alongside ack and ready.
        bundle("fl_a", 2'd2, 1'b0);
        bundle("fl_b", 2'd1, 1'b0);
        cycle("flush", 1'b1, 2'd2, 20'hAAAAA, 20'hBBBBB, 20'hCCCCC, 1'b1, 1'b1);
        idle("post_flush", 1'b0);
        bundle("after_fl", 2'd0, 1'b1);
        idle("after_fl2", 1'b1);

        // Same fill, then asynchronous reset mid-drain.
        bundle("rs_a", 2'd2, 1'b0);
        bundle("rs_b", 2'd1, 1'b1);
        idle("rs_drain", 1'b1);
        async_reset("middrain");
        idle("post_rst", 1'b1);

        // Randomized traffic, including illegal count 3 and unrequested acks.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  20'($urandom), 20'($urandom), 20'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 10; i++) idle("final_drain", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
